// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning N-channel multiplexer.
package mux_scan_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Channel-index width: at least one bit, even for a two-channel mux.
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Circular priority search: first set mask bit strictly above cur, wrapping
// through zero and ending back at cur itself. Driving cur with N_CH-1 yields
// the lowest set bit of the mask.
module mux_next_ch
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic             found
);

  logic hit;

  // Walk the channels in circular order starting just after cur.
  always_comb begin
    nxt = '0;
    hit = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      int idx;
      idx = (int'(cur) + k) % N_CH;
      if (!hit && mask[idx]) begin
        hit = 1'b1;
        nxt = SEL_W'(idx);
      end
    end
    found = |mask;
    wrap  = hit && (nxt <= cur);
  end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with a manual select mode and an
// automatic round-robin scan mode over an enable mask with programmable dwell.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter  int N_CH    = 8,
  parameter  int W       = 8,
  parameter  int DWELL_W = 4,
  localparam int SEL_W   = sel_w(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   d,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mode,
  input  logic [N_CH-1:0]     en_mask,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic                start,
  output logic [W-1:0]        y,
  output logic [SEL_W-1:0]    y_ch,
  output logic                y_valid,
  output logic                scan_wrap,
  output logic                busy
);

  state_t             state;
  logic [SEL_W-1:0]   cur;
  logic [DWELL_W-1:0] cnt;

  logic [SEL_W-1:0]   nxt;
  logic               nxt_wrap;
  logic               nxt_found;
  logic [SEL_W-1:0]   low;
  logic               low_wrap_unused;
  logic               low_found;

  // Next enabled channel after the one currently dwelling (live mask).
  mux_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_next (
    .mask  (en_mask),
    .cur   (cur),
    .nxt   (nxt),
    .wrap  (nxt_wrap),
    .found (nxt_found)
  );

  // Lowest enabled channel, used when a scan starts or restarts.
  mux_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_low (
    .mask  (en_mask),
    .cur   (SEL_W'(N_CH - 1)),
    .nxt   (low),
    .wrap  (low_wrap_unused),
    .found (low_found)
  );

  assign busy = (state == DWELL);

  // Scan FSM and registered output stage; strobes default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      cnt       <= '0;
      y         <= '0;
      y_ch      <= '0;
      y_valid   <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      y_valid   <= 1'b0;
      scan_wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (mode == MODE_MANUAL) begin
            y_ch <= sel;
            if (int'(sel) < N_CH) begin
              y       <= d[int'(sel)*W +: W];
              y_valid <= 1'b1;
            end else begin
              y <= '0;
            end
          end else if (start && low_found) begin
            cur   <= low;
            cnt   <= '0;
            state <= DWELL;
          end
        end
        DWELL: begin
          if (mode == MODE_MANUAL) begin
            // Abort: manual sampling resumes from IDLE on the next cycle.
            state <= IDLE;
            cnt   <= '0;
          end else if (!nxt_found) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (start) begin
            cur <= low;
            cnt <= '0;
          end else if (!en_mask[cur]) begin
            // Current channel was disabled before its sample: skip it.
            cur <= nxt;
            cnt <= '0;
          end else if (cnt >= dwell) begin
            y         <= d[int'(cur)*W +: W];
            y_ch      <= cur;
            y_valid   <= 1'b1;
            scan_wrap <= nxt_wrap;
            cur       <= nxt;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench for mux_scan_n (N_CH=8, W=8, DWELL_W=4).
module tb_mux_scan_n;

  localparam int N_CH = 8;
  localparam int W    = 8;
  localparam int DW   = 4;

  typedef struct {
    int         cyc;
    logic [7:0] y;
    logic [2:0] ch;
    logic       wrap;
  } exp_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] y;
    logic [2:0] ch;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH*W-1:0] d;
  logic [2:0]        sel;
  logic              mode;
  logic [N_CH-1:0]   en_mask;
  logic [DW-1:0]     dwell;
  logic              start;
  logic [W-1:0]      y;
  logic [2:0]        y_ch;
  logic              y_valid;
  logic              scan_wrap;
  logic              busy;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  vec_t tbl[10];

  mux_scan_n #(.N_CH(N_CH), .W(W), .DWELL_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .sel       (sel),
    .mode      (mode),
    .en_mask   (en_mask),
    .dwell     (dwell),
    .start     (start),
    .y         (y),
    .y_ch      (y_ch),
    .y_valid   (y_valid),
    .scan_wrap (scan_wrap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [2:0] ch, input logic wrap);
    exp_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.y    = 8'hA0 + {5'd0, ch};
    e.wrap = wrap;
    q.push_back(e);
  endtask

  task automatic wait_empty();
    int g = 0;
    while (q.size() != 0 && g < 100) begin
      tick();
      g++;
    end
    if (q.size() != 0) begin
      chk("sample_timeout_pending", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic mon();
    exp_t e;
    if (y_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid_ch", {29'd0, y_ch}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("sample_cycle", cyc, e.cyc);
        chk("sample_y", {24'd0, y}, {24'd0, e.y});
        chk("sample_ch", {29'd0, y_ch}, {29'd0, e.ch});
        chk("sample_wrap", {31'd0, scan_wrap}, {31'd0, e.wrap});
      end
    end else if (scan_wrap) begin
      chk("wrap_without_valid", {31'd0, scan_wrap}, 0);
    end
  endtask

  initial begin
    int k;
    logic [2:0] chs [6];

    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none

    for (int i = 0; i < N_CH; i++) d[i*W +: W] = 8'hA0 + 8'(i);
    for (int i = 0; i < 8; i++) begin
      tbl[i].sel = 3'(i);
      tbl[i].y   = 8'hA0 + 8'(i);
      tbl[i].ch  = 3'(i);
    end
    tbl[8].sel = 3'd5; tbl[8].y = 8'hA5; tbl[8].ch = 3'd5;
    tbl[9].sel = 3'd2; tbl[9].y = 8'hA2; tbl[9].ch = 3'd2;

    rst_n = 1'b0; mode = 1'b1; start = 1'b0; sel = '0; en_mask = '0; dwell = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_y", {24'd0, y}, 0);
    chk("reset_y_ch", {29'd0, y_ch}, 0);
    chk("reset_y_valid", {31'd0, y_valid}, 0);
    chk("reset_scan_wrap", {31'd0, scan_wrap}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    tick();

    // Manual sweep, one sample per cycle with one cycle of latency.
    mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sel = tbl[i].sel;
      push(cyc + 1, tbl[i].ch, 1'b0);
      q[q.size()-1].y = tbl[i].y;
      tick();
    end
    mode = 1'b1;
    wait_empty();
    tick();
    chk("idle_scan_no_valid", {31'd0, y_valid}, 0);

    // Scan over channels 0,2,5,7 with dwell 2: one sample every 3 cycles.
    chs[0] = 3'd0; chs[1] = 3'd2; chs[2] = 3'd5; chs[3] = 3'd7; chs[4] = 3'd0; chs[5] = 3'd2;
    k = cyc;
    en_mask = 8'b1010_0101; dwell = 4'd2; start = 1'b1;
    for (int i = 0; i < 6; i++) push(k + 4 + 3*i, chs[i], chs[i] == 3'd7);
    tick();
    start = 1'b0;
    chk("scan_busy", {31'd0, busy}, 1);
    wait_empty();
    en_mask = '0;
    tick();
    chk("mask_zero_idle", {31'd0, busy}, 0);

    // Single channel, dwell 0: back-to-back samples, wrap on each.
    k = cyc;
    en_mask = 8'b0001_0000; dwell = 4'd0; start = 1'b1;
    for (int i = 0; i < 5; i++) push(k + 2 + i, 3'd4, 1'b1);
    tick();
    start = 1'b0;
    repeat (5) tick();
    en_mask = '0;
    tick();
    chk("single_ch_stop_busy", {31'd0, busy}, 0);
    wait_empty();

    // Channel 2 disabled mid-dwell: its sample is skipped, ch5 follows.
    k = cyc;
    en_mask = 8'b1010_0101; dwell = 4'd3; start = 1'b1;
    push(k + 5, 3'd0, 1'b0);
    push(k + 11, 3'd5, 1'b0);
    push(k + 15, 3'd7, 1'b1);
    tick();
    start = 1'b0;
    repeat (5) tick();
    en_mask = 8'b1010_0001;
    wait_empty();
    en_mask = '0;
    tick();

    // Abort scan by switching to manual: one-cycle gap, then manual data.
    k = cyc;
    en_mask = 8'b1010_0101; dwell = 4'd2; sel = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mode = 1'b0;
    tick();
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_gap_valid", {31'd0, y_valid}, 0);
    push(cyc + 1, 3'd3, 1'b0);
    tick();
    mode = 1'b1;
    wait_empty();

    // Asynchronous reset between clock edges during a scan.
    k = cyc;
    en_mask = 8'b1010_0101; dwell = 4'd2; start = 1'b1;
    push(k + 4, 3'd0, 1'b0);
    tick();
    start = 1'b0;
    wait_empty();
    chk("pre_reset_y", {24'd0, y}, 32'hA0);
    chk("pre_reset_busy", {31'd0, busy}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_y", {24'd0, y}, 0);
    chk("async_reset_y_ch", {29'd0, y_ch}, 0);
    chk("async_reset_valid", {31'd0, y_valid}, 0);
    chk("async_reset_wrap", {31'd0, scan_wrap}, 0);
    chk("async_reset_busy", {31'd0, busy}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_busy", {31'd0, busy}, 0);
    chk("post_reset_valid", {31'd0, y_valid}, 0);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
